// File: rtl/ram_copy_engine.sv
// Block COPY / FILL engine driving a single-port RAM (combinational read, clocked write).
// Words are processed in ascending order; COPY costs a READ and a WRITE cycle per word.
module ram_copy_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic [WIDTH-1:0] length,
    input  logic [WIDTH-1:0] fill_value,
    output logic             busy,
    output logic             done,
    output logic             memory_write_enable,
    output logic [WIDTH-1:0] address_rw,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] dst_q, dst_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] fill_q, fill_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] rbuf_q, rbuf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        i_d     = i_q;
        rbuf_d  = rbuf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = length;
                    fill_d = fill_value;
                    i_d    = '0;
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                rbuf_d  = data_out;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                i_d = i_q + 1'b1;
                if (i_d == len_q) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they come straight out of flops;
    // address and write data hold their last value outside READ/WRITE.
    always_comb begin
        busy_d  = (state_d == S_READ) || (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        we_d    = (state_d == S_WRITE);
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_d)
            S_READ: begin
                addr_d = src_d + i_d;
            end
            S_WRITE: begin
                addr_d  = dst_d + i_d;
                wdata_d = mode_d ? fill_d : rbuf_d;
            end
            default: begin
                addr_d  = addr_q;
                wdata_d = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            i_q     <= '0;
            rbuf_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            i_q     <= i_d;
            rbuf_q  <= rbuf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign memory_write_enable = we_q;
    assign address_rw          = addr_q;
    assign data_in             = wdata_q;

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Memory-access initiator that drives the single-port RAM interface: write enable, address, write data out; read data in.
- RAM read is combinational; writes commit on the clock edge.
- Performs block operations on RAM contents under a start/done handshake:
  - COPY: moves a block from a source address to a destination address.
  - FILL: writes a constant to a block of addresses.
- Sits between control logic and the RAM so the control logic does not sequence individual word accesses.

Parameters:
- WIDTH, 8, address and data width in bits (same value as the attached RAM); RAM depth is 2**WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = COPY, 1 = FILL; latched with start.
- src_addr  input  WIDTH  COPY source base address; latched with start.
- dst_addr  input  WIDTH  destination base address; latched with start.
- length  input  WIDTH  number of words to process; latched with start; 0 means no accesses.
- fill_value  input  WIDTH  FILL data word; latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when an operation completes.
- memory_write_enable  output  1  RAM write enable.
- address_rw  output  WIDTH  RAM address.
- data_in  output  WIDTH  RAM write data.
- data_out  input  WIDTH  RAM read data, valid in the same cycle as address_rw.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; busy = 0; done = 0; memory_write_enable = 0; address_rw = 0; data_in = 0.
  - Internal counter, latched operands and read buffer cleared.
  - Reset mid-operation aborts immediately: no further writes, and no done pulse for the aborted operation.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - memory_write_enable = 0.
  - On start = 1, latch mode, src_addr, dst_addr, length and fill_value, and clear index i.
  - length = 0 -> DONE.
  - Otherwise COPY -> READ; FILL -> WRITE.
  - start while not in IDLE is ignored; operands are not relatched.
- READ (COPY only):
  - address_rw = src + i; memory_write_enable = 0.
  - At the clock edge, data_out is captured into the read buffer; next state WRITE.
- WRITE:
  - address_rw = dst + i; memory_write_enable = 1.
  - data_in = read buffer (COPY) or latched fill_value (FILL).
  - At the clock edge, i increments.
  - If i + 1 == length -> DONE.
  - Otherwise COPY -> READ, FILL -> WRITE.
- DONE:
  - done = 1 for exactly this cycle; memory_write_enable = 0; next state IDLE.
  - start is not accepted in DONE; it is accepted from the following IDLE cycle.
- Outputs are decoded from registered state and registered counters. memory_write_enable is never high outside WRITE.
- busy = 1 in READ and WRITE, and 0 in IDLE and DONE.
- Address arithmetic is modulo 2**WIDTH: src + i and dst + i wrap from 2**WIDTH - 1 to 0.
- Counter i is WIDTH bits. Maximum length is 2**WIDTH - 1.
- Words are processed in ascending order. Overlapping COPY with dst > src therefore propagates already-copied words; this is the defined behaviour.
- Latency, with start sampled at edge 0:
  - COPY of N words: busy for 2N cycles, done in cycle 2N + 1.
  - FILL of N words: busy for N cycles, done in cycle N + 1.
  - length = 0: done in cycle 1 with no RAM access.
- Between operations, address_rw holds its last value and data_in holds its last value. The verifier checks neither outside WRITE.

Test Plan:
- FILL: WIDTH = 8, dst = 0x10, length = 4, fill_value = 0xA5 -> writes 0xA5 to 0x10..0x13 on 4 consecutive cycles; done in cycle 5; 0x0F and 0x14 unchanged.
- COPY: RAM[0x20..0x22] = {0x11, 0x22, 0x33}, src = 0x20, dst = 0x40, length = 3 -> RAM[0x40..0x42] = {0x11, 0x22, 0x33}; memory_write_enable alternates 0, 1 for 6 cycles; done in cycle 7.
- Wrap-around: FILL dst = 0xFE, length = 3, fill_value = 0x5C -> addresses 0xFE, 0xFF, 0x00 written; 0x01 untouched.
- length = 0 with start -> no write-enable pulse; done high in cycle 1 only; busy never asserted.
- start held high during a 3-word COPY, with src/dst inputs changed mid-operation -> operation uses the operands latched at the first start. A second operation begins only from the IDLE cycle after done.
- rst_n low during the WRITE of word 2 of a 4-word FILL:
  - memory_write_enable drops immediately and all outputs are 0.
  - Only words 0 and 1 are modified, and no done pulse occurs.
  - After release, a new start executes normally.
